// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mul_pkg;

  // Control FSM states: IDLE holds the last result, RUN retires two multiplier bits per edge.
  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Partial-product selection produced by the Booth recoder.
  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_PA,
    SEL_P2A,
    SEL_NA,
    SEL_N2A
  } booth_sel_t;

  // Number of Booth steps for a given operand width. The operands are extended
  // by two bits, which gives one extra step so unsigned operands with MSB=1 work.
  function automatic int booth_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: multiplier triplet {b[2i+1], b[2i], b[2i-1]} to a partial-product select.
// Latency: combinational.
// Backpressure: none.
module booth_r4_enc
  import mul_pkg::*;
(
  input  logic [2:0] trip,
  output booth_sel_t sel,
  output logic       neg
);

  // Recode the triplet; neg marks the subtracting selections.
  always_comb begin
    sel = SEL_ZERO;
    neg = 1'b0;
    unique case (trip)
      3'b000: sel = SEL_ZERO;
      3'b001: sel = SEL_PA;
      3'b010: sel = SEL_PA;
      3'b011: sel = SEL_P2A;
      3'b100: begin sel = SEL_N2A; neg = 1'b1; end
      3'b101: begin sel = SEL_NA;  neg = 1'b1; end
      3'b110: begin sel = SEL_NA;  neg = 1'b1; end
      3'b111: sel = SEL_ZERO;
    endcase
  end

endmodule

// File: rtl/seq_mul_booth.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation, WIDTH x WIDTH -> 2*WIDTH.
// Latency: WIDTH/2+1 edges after the accepting edge; done pulses on the edge that writes out.
// Backpressure: start is accepted only while ready=1; a start during RUN is dropped.
module seq_mul_booth
  import mul_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   out,
  output logic                 ready,
  output logic                 done
);

  // EW: extended operand width. HW: upper accumulator half, two guard bits above
  // EW so a +/-2A addition on top of the running partial sum cannot overflow.
  localparam int EW   = WIDTH + 2;
  localparam int HW   = EW + 2;
  localparam int ITER = booth_iter(WIDTH);
  localparam int CW   = $clog2(ITER + 1);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("seq_mul_booth: WIDTH must be even and at least 4");
  end

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [EW-1:0]    a_q;
  logic [HW-1:0]    hi_q;
  logic [EW-1:0]    lo_q;
  logic             prev_q;

  logic             accept;
  logic             finish;
  logic             last_step;
  logic [EW-1:0]    a_ext;
  logic [EW-1:0]    b_ext;
  logic [HW-1:0]    a1;
  logic [HW-1:0]    a2;
  logic [HW-1:0]    mag;
  logic [HW-1:0]    addend;
  logic [HW-1:0]    sum;
  logic [HW-1:0]    hi_nx;
  logic [EW-1:0]    lo_nx;
  booth_sel_t       sel;
  logic             neg;

  assign ready = (state_q == IDLE);

  // Operands are widened by two bits; sign or zero fill depends on the mode bit.
  assign a_ext = signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
  assign b_ext = signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

  // The low two multiplier bits still in lo_q, plus the last bit shifted out, form the triplet.
  booth_r4_enc u_enc (
    .trip ({lo_q[1], lo_q[0], prev_q}),
    .sel  (sel),
    .neg  (neg)
  );

  assign a1 = {{2{a_q[EW-1]}}, a_q};
  assign a2 = {a_q[EW-1], a_q, 1'b0};

  // Pick the magnitude of the partial product; negation is applied separately below.
  always_comb begin
    mag = '0;
    case (sel)
      SEL_PA, SEL_NA:   mag = a1;
      SEL_P2A, SEL_N2A: mag = a2;
      default:          mag = '0;
    endcase
  end

  // Two's-complement subtract folded into the adder: invert and carry in.
  assign addend = mag ^ {HW{neg}};
  assign sum    = hi_q + addend + {{(HW-1){1'b0}}, neg};

  // Arithmetic shift right by two across {hi, lo}; product bits enter lo from the top
  // as multiplier bits leave from the bottom.
  assign hi_nx = {{2{sum[HW-1]}}, sum[HW-1:2]};
  assign lo_nx = {sum[1:0], lo_q[EW-1:2]};

  assign last_step = (cnt_q == CW'(ITER - 1));

  // Next-state logic: accept in IDLE on start, leave RUN after the last Booth step.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: load on accept, one Booth step per RUN edge, publish result on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      prev_q <= 1'b0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        a_q    <= a_ext;
        hi_q   <= '0;
        lo_q   <= b_ext;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else if (state_q == RUN) begin
        hi_q   <= hi_nx;
        lo_q   <= lo_nx;
        prev_q <= lo_q[1];
        cnt_q  <= cnt_q + 1'b1;
      end
      if (finish) begin
        out <= {hi_nx[WIDTH-3:0], lo_nx};
      end
    end
  end

endmodule
